// File: rtl/u41_cfg_loader_pkg.sv
// Shared constants, FSM state type and shift-length helper for the u41 configuration loader.
// Optional feature macro: U41_CFG_PARITY_EN (appends an even-parity bit to the serial stream).
// Used by u41_cfg_loader and u41_cfg_piso.
package u41_pkg;

    localparam int U41_PINS     = 10;
    localparam int U41_WBITS    = 3;
    localparam int U41_CFG_BITS = U41_PINS * U41_WBITS;

`ifdef U41_CFG_PARITY_EN
    // Word bits followed by one trailing parity bit.
    localparam int U41_SHIFT_LEN = U41_CFG_BITS + 1;
`else
    localparam int U41_SHIFT_LEN = U41_CFG_BITS;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_LATCH  = 2'd3
    } u41_state_t;

endpackage

// File: rtl/u41_cfg_loader_piso.sv
// Parallel-load, MSB-first shift register feeding the gate configuration chain.
// Latency: dout valid the cycle after load; one bit per shift cycle.
// No backpressure: shifts whenever shift is high; done flags the final bit.
module u41_cfg_piso
    import u41_pkg::*;
#(
    parameter int LEN = U41_SHIFT_LEN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [LEN-1:0] load_dat,
    input  logic           shift,
    output logic           dout,
    output logic           done
);

    localparam int CW = $clog2(LEN + 1);

    logic [LEN-1:0] sr;
    logic [CW-1:0]  bit_cnt;

    // Load the whole word at once, then move it out MSB first while counting bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= load_dat;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {sr[LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign dout = sr[LEN-1];
    assign done = (bit_cnt == CW'(LEN - 1));

endmodule

// File: rtl/u41_cfg_loader.sv
// Accepts a 16-bit function, walks the wiring lookup over all pin slots, shifts the word out, pulses latch.
// Latency: accept at cycle 0, latch at cycle 41 (42 with U41_CFG_PARITY_EN); one function per 42 (43) cycles.
// Backpressure: req_ready is high only in IDLE; nothing is queued, req_func is sampled only at acceptance.
module u41_cfg_loader
    import u41_pkg::*;
#(
    parameter int PINS  = U41_PINS,
    parameter int WBITS = U41_WBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_func,
    output logic [15:0]      lut_func,
    output logic [3:0]       lut_pin,
    input  logic [WBITS-1:0] lut_wiring,
    output logic             cfg_shift,
    output logic             cfg_data,
    output logic             cfg_latch,
    output logic             busy
);

    localparam int CBITS = PINS * WBITS;
    // Parity mode adds exactly one bit beyond the assembled word.
    localparam int SLEN  = CBITS + (U41_SHIFT_LEN - U41_CFG_BITS);

    u41_state_t       state, nxt;
    logic [15:0]      func_q;
    logic [CBITS-1:0] word;
    logic [CBITS-1:0] word_nxt;
    logic [3:0]       pin_cnt;
    logic             last_pin;
    logic             accept;
    logic [SLEN-1:0]  load_dat;
    logic             sh_dout;
    logic             sh_done;

    assign accept   = req_valid && req_ready;
    assign last_pin = (pin_cnt == 4'(PINS - 1));

    // Merge the wiring code returned this cycle into its slot of the word.
    always_comb begin
        word_nxt = word;
        word_nxt[WBITS*pin_cnt +: WBITS] = lut_wiring;
    end

`ifdef U41_CFG_PARITY_EN
    assign load_dat = {word_nxt, ^word_nxt};
`else
    assign load_dat = word_nxt;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (accept)   nxt = ST_LOOKUP;
            ST_LOOKUP: if (last_pin) nxt = ST_SHIFT;
            ST_SHIFT:  if (sh_done)  nxt = ST_LATCH;
            ST_LATCH:                nxt = ST_IDLE;
            default:                 nxt = ST_IDLE;
        endcase
    end

    // Capture the request and step the lookup one pin slot per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            func_q  <= '0;
            word    <= '0;
            pin_cnt <= '0;
        end else begin
            if (accept) begin
                func_q  <= req_func;
                pin_cnt <= '0;
            end
            if (state == ST_LOOKUP) begin
                word    <= word_nxt;
                // Wrap on the last slot so the slot index never leaves the word.
                pin_cnt <= last_pin ? 4'd0 : pin_cnt + 4'd1;
            end
        end
    end

    // State-decoded outputs, all forced low while reset is asserted.
    always_comb begin
        req_ready = 1'b0;
        lut_pin   = 4'd0;
        cfg_shift = 1'b0;
        cfg_data  = 1'b0;
        cfg_latch = 1'b0;
        busy      = 1'b0;
        lut_func  = rst ? 16'd0 : func_q;
        if (!rst) begin
            case (state)
                ST_IDLE: req_ready = 1'b1;
                ST_LOOKUP: begin
                    busy    = 1'b1;
                    lut_pin = pin_cnt;
                end
                ST_SHIFT: begin
                    busy      = 1'b1;
                    cfg_shift = 1'b1;
                    cfg_data  = sh_dout;
                end
                ST_LATCH: begin
                    busy      = 1'b1;
                    cfg_latch = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    u41_cfg_piso #(
        .LEN (SLEN)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == ST_LOOKUP) && last_pin),
        .load_dat (load_dat),
        .shift    (state == ST_SHIFT),
        .dout     (sh_dout),
        .done     (sh_done)
    );

endmodule

// File: tb/tb_u41_cfg_loader.sv
// Bench for u41_cfg_loader: directed loads with a scoreboard of expected lookups, serial bits and latch timing.
// Lookup model: wiring code = lut_pin[2:0], which fixes the assembled word for every load.
// Stimulus pushes expectations; a negedge monitor pops and compares whenever the DUT presents output.
module tb_u41_cfg_loader;

`ifdef U41_CFG_PARITY_EN
    localparam int SLEN = 31;
    localparam int LAT  = 42;
`else
    localparam int SLEN = 30;
    localparam int LAT  = 41;
`endif

    // Slots 9..0 carry codes 1,0,7,6,5,4,3,2,1,0; bit 29 leaves first. Popcount 13, parity 1.
    localparam logic [29:0] WORD = 30'b001_000_111_110_101_100_011_010_001_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_func;
    logic [15:0] lut_func;
    logic [3:0]  lut_pin;
    logic [2:0]  lut_wiring;
    logic        cfg_shift;
    logic        cfg_data;
    logic        cfg_latch;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  pin;
        logic [15:0] func;
    } lk_t;

    lk_t  exp_lk[$];
    logic exp_bit[$];
    int   exp_lat[$];
    int   acc_log[$];

    u41_cfg_loader dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_func   (req_func),
        .lut_func   (lut_func),
        .lut_pin    (lut_pin),
        .lut_wiring (lut_wiring),
        .cfg_shift  (cfg_shift),
        .cfg_data   (cfg_data),
        .cfg_latch  (cfg_latch),
        .busy       (busy)
    );

    assign lut_wiring = lut_pin[2:0];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL unexpected_%s: got an output, want none (cycle %0d)", nm, cyc);
    endtask

    task automatic push_load(input logic [15:0] func);
        logic [29:0] w;
        w = WORD;
        for (int p = 0; p < 10; p++) exp_lk.push_back('{pin: 4'(p), func: func});
        for (int i = 0; i < 30; i++) exp_bit.push_back(w[29-i]);
        if (SLEN == 31) exp_bit.push_back(1'b1);
        exp_lat.push_back(LAT);
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) unexpected("busy_timeout");
    endtask

    task automatic run_load(input logic [15:0] func);
        push_load(func);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_func  = func;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    // Monitor / scoreboard.
    int   acc_cyc  = 0;
    bit   chk_idle = 1'b0;
    lk_t  lk;
    logic eb;
    int   el;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_outs", {7'd0, req_ready, cfg_shift, cfg_data, cfg_latch, busy, lut_pin, lut_func}, 32'd0);
            exp_lk.delete();
            exp_bit.delete();
            exp_lat.delete();
            chk_idle = 1'b0;
        end else begin
            check("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
            if (chk_idle) begin
                check("idle_after_latch", {30'd0, busy, req_ready}, 32'd1);
                chk_idle = 1'b0;
            end
            if (req_valid && req_ready) begin
                acc_cyc = cyc;
                acc_log.push_back(cyc);
            end
            if (busy && !cfg_shift && !cfg_latch) begin
                if (exp_lk.size() == 0) unexpected("lookup");
                else begin
                    lk = exp_lk.pop_front();
                    check("lut_pin", {28'd0, lut_pin}, {28'd0, lk.pin});
                    check("lut_func", {16'd0, lut_func}, {16'd0, lk.func});
                end
            end else begin
                check("lut_pin_idle", {28'd0, lut_pin}, 32'd0);
            end
            if (cfg_shift) begin
                if (exp_bit.size() == 0) unexpected("shift");
                else begin
                    eb = exp_bit.pop_front();
                    check("cfg_data", {31'd0, cfg_data}, {31'd0, eb});
                end
            end else begin
                check("cfg_data_idle", {31'd0, cfg_data}, 32'd0);
            end
            if (cfg_latch) begin
                if (exp_lat.size() == 0) unexpected("latch");
                else begin
                    el = exp_lat.pop_front();
                    check("latch_cycle", cyc - acc_cyc, el);
                    chk_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got2;

        // Reset held with a pending request that must be ignored.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_func  = 16'hBEEF;
        repeat (4) @(posedge clk);
        #1;
        check("no_acc_in_rst", acc_log.size(), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {14'd0, req_ready, busy, lut_func}, {14'd0, 1'b1, 1'b0, 16'h0000});

        // Basic load.
        run_load(16'h8000);
        check("ready_idle", {31'd0, req_ready}, 32'd1);

        // Back-to-back with valid held high; req_func changes mid-load.
        acc_log.delete();
        push_load(16'h1234);
        push_load(16'h5555);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_func  = 16'h1234;
        repeat (5) @(posedge clk);
        #1;
        req_func = 16'h5555;
        got2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_log.size() >= 2) begin
                got2 = 1'b1;
                break;
            end
        end
        if (!got2) unexpected("second_accept_timeout");
        else check("accept_gap", acc_log[1] - acc_log[0], LAT + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();

        // Reset in the middle of SHIFT (cycle 20 after accept).
        push_load(16'h00F0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_func  = 16'h00F0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("in_shift_c19", {31'd0, cfg_shift}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort", {28'd0, cfg_shift, busy, cfg_latch, req_ready}, 32'b0001);
        repeat (50) @(negedge clk);

        // Clean load after the abort.
        run_load(16'hA5A5);

        check("sb_drain", exp_lk.size() + exp_bit.size() + exp_lat.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
